uart_rx_core: RTL and testbench

- Asynchronous serial receiver for an 8-bit UART frame: 1 start bit, 8 data bits LSB first, 1 even-parity bit, and 1 or more stop bits.
- Samples each bit at its midpoint and presents the received byte on data.
- Flags each new byte with a sticky ready that the consumer clears with reset_ready.
- Sits between the board RX pin and the host-side logic; tx_o is the matching serial output pin.

---
 rtl/uart_rx_core.sv | 246 ++++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core
//   Serial receiver for 8-bit UART frames. A frame is 1 start bit, 8 data bits
//   sent LSB first, 1 even-parity bit and one or more stop bits. Each bit is
//   sampled at its midpoint. Only bytes with good parity and a good stop bit are
//   published.
//
// Ports
//   clk          rising-edge system clock
//   reset        asynchronous, active-high reset
//   rx_i         serial receive line (idle high, asynchronous to clk)
//   reset_ready  level-high clear of ready (sampled on clk)
//   data         last good received byte
//   ready        sticky "new byte available" flag
//   tx_o         serial transmit line (idle high)
//
// Build option
//   UART_RX_ECHO_EN : when defined, every committed byte is echoed on tx_o with
//                     the same framing and 2 stop bits. A byte committed while
//                     the echo is still busy is dropped. When undefined, tx_o is
//                     tied high.
`timescale 1ns/1ps
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  input  logic       reset_ready,
  output logic [7:0] data,
  output logic       ready,
  output logic       tx_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Even parity: the parity bit makes the count of ones in the frame even.
  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_err_q, par_err_d;
  logic             commit_q, commit_d;
  logic [7:0]       data_q, data_d;
  logic             ready_q, ready_d;

  // Two-flop synchronizer for the asynchronous rx line (resets to idle level).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receive FSM next-state: cnt times mid-bit samples, commit pulses one clk later.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    commit_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = 3'd0;
        if (!rx_sync_q) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        // Half a bit in: a line that is high again was only a glitch.
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_err_d = rx_sync_q ^ even_par(shift_q);
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        // A low stop bit (framing error) or a parity error discards the byte.
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          commit_d = rx_sync_q & ~par_err_q;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next-state: a commit beats a simultaneous reset_ready.
  always_comb begin
    data_d  = data_q;
    ready_d = ready_q;
    if (commit_q) begin
      data_d  = shift_q;
      ready_d = 1'b1;
    end else if (reset_ready) begin
      ready_d = 1'b0;
    end else begin
      ready_d = ready_q;
    end
  end

  // Receive state and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      par_err_q <= 1'b0;
      commit_q  <= 1'b0;
      data_q    <= 8'h00;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      commit_q  <= commit_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
    end
  end

  assign data  = data_q;
  assign ready = ready_q;

`ifdef UART_RX_ECHO_EN
  logic             tx_busy_q, tx_busy_d;
  logic             tx_q, tx_d;
  logic [10:0]      tx_shift_q, tx_shift_d;
  logic [3:0]       tx_left_q, tx_left_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;

  // Echo transmitter next-state: tx_q is the bit on the line, tx_shift_q holds the
  // bits still to go and tx_left_q counts them.
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_d       = tx_q;
    tx_shift_d = tx_shift_q;
    tx_left_d  = tx_left_q;
    tx_cnt_d   = tx_cnt_q;
    if (tx_busy_q) begin
      if (tx_cnt_q == CNT_LAST) begin
        tx_cnt_d = '0;
        if (tx_left_q == 4'd0) begin
          tx_busy_d = 1'b0;
          tx_d      = 1'b1;
        end else begin
          tx_d       = tx_shift_q[0];
          tx_shift_d = {1'b1, tx_shift_q[10:1]};
          tx_left_d  = tx_left_q - 4'd1;
        end
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end else if (commit_q) begin
      // Start bit goes out now; data, parity and two stop bits are queued behind it.
      tx_busy_d  = 1'b1;
      tx_d       = 1'b0;
      tx_shift_d = {2'b11, even_par(shift_q), shift_q};
      tx_left_d  = 4'd11;
      tx_cnt_d   = '0;
    end else begin
      tx_d = 1'b1;
    end
  end

  // Echo transmitter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_busy_q  <= 1'b0;
      tx_q       <= 1'b1;
      tx_shift_q <= 11'h7FF;
      tx_left_q  <= 4'd0;
      tx_cnt_q   <= '0;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_q       <= tx_d;
      tx_shift_q <= tx_shift_d;
      tx_left_q  <= tx_left_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  assign tx_o = tx_q;
`else
  assign tx_o = 1'b1;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int CPB    = 20;
  localparam int BIT_NS = 400;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_i;
  logic       reset_ready;
  logic [7:0] data;
  logic       ready;
  logic       tx_o;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_data;
  logic       exp_ready;

  always #10 clk = ~clk;

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_i        (rx_i),
    .reset_ready (reset_ready),
    .data        (data),
    .ready       (ready),
    .tx_o        (tx_o)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // Frame as sent on the wire, index 0 first: start, data LSB first, parity, stop.
  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par,
                                             input bit bad_stop);
    logic par;
    par = (^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  // Reference model: only a frame with correct parity and stop publishes the byte.
  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (!bad_par && !bad_stop) begin
      exp_data  = b;
      exp_ready = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f = make_frame(b, bad_par, bad_stop);
    for (int i = 0; i < 11; i++) begin
      rx_i = f[i];
      #(BIT_NS);
    end
    rx_i = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rx_i = 1'b1;
    #(BIT_NS * n);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_data"}, {8'h00, data}, {8'h00, exp_data});
    chk({tag, "_ready"}, {15'h0, ready}, {15'h0, exp_ready});
`ifndef UART_RX_ECHO_EN
    chk({tag, "_tx"}, {15'h0, tx_o}, 16'h0001);
`endif
  endtask

  task automatic clear_ready();
    @(negedge clk);
    reset_ready = 1'b1;
    @(negedge clk);
    reset_ready = 1'b0;
    exp_ready   = 1'b0;
  endtask

  initial begin
    logic [7:0]  b;
    int          mode;
    bit          seen;
    logic [11:0] echo_bits;

    reset       = 1'b1;
    rx_i        = 1'b1;
    reset_ready = 1'b0;
    exp_data    = 8'h00;
    exp_ready   = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("in_reset");
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check_outputs("after_reset_idle");

    // Basic frame 8'h1D, ready visible in first stop bit and still in second.
    send_frame(8'h1D, 1'b0, 1'b0);
    model_frame(8'h1D, 1'b0, 1'b0);
    check_outputs("rx_1d_stop1");
    idle_bits(1);
    check_outputs("rx_1d_stop2");

    // Clear, then 8'hA5.
    clear_ready();
    check_outputs("clear_after_1d");
    send_frame(8'hA5, 1'b0, 1'b0);
    model_frame(8'hA5, 1'b0, 1'b0);
    check_outputs("rx_a5");
    idle_bits(1);

    // Parity error and framing error both discard.
    clear_ready();
    send_frame(8'h1D, 1'b1, 1'b0);
    model_frame(8'h1D, 1'b1, 1'b0);
    idle_bits(1);
    check_outputs("bad_parity");
    send_frame(8'h1D, 1'b0, 1'b1);
    model_frame(8'h1D, 1'b0, 1'b1);
    idle_bits(12);
    check_outputs("bad_stop");

    // Short glitch is rejected; following frame is good.
    rx_i = 1'b0;
    #100;
    rx_i = 1'b1;
    #300;
    check_outputs("glitch");
    send_frame(8'h3C, 1'b0, 1'b0);
    model_frame(8'h3C, 1'b0, 1'b0);
    check_outputs("rx_3c");
    idle_bits(1);

    // reset_ready held high across a commit: commit must win.
    @(negedge clk);
    reset_ready = 1'b1;
    seen        = 1'b0;
    fork
      send_frame(8'hC3, 1'b0, 1'b0);
      begin
        repeat (4) @(negedge clk);
        for (int i = 0; i < CPB * 13; i++) begin
          @(negedge clk);
          if (ready === 1'b1) begin
            seen        = 1'b1;
            reset_ready = 1'b0;
            break;
          end
        end
      end
    join
    reset_ready = 1'b0;
    chk("commit_wins_seen", {15'h0, seen}, 16'h0001);
    model_frame(8'hC3, 1'b0, 1'b0);
    check_outputs("commit_wins");
    idle_bits(1);

    // Randomized frames against the model, including overrun when not cleared.
    for (int n = 0; n < 10; n++) begin
      b    = 8'($urandom);
      mode = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        clear_ready();
        check_outputs("rand_clear");
      end
      send_frame(b, mode == 2, mode == 3);
      model_frame(b, mode == 2, mode == 3);
      check_outputs("rand_frame");
      idle_bits(12);
      check_outputs("rand_idle");
    end

    // Reset in the middle of the data bits aborts the frame.
    rx_i = 1'b0;
    #(BIT_NS);
    rx_i = 1'b1;
    #(BIT_NS * 3);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    exp_data  = 8'h00;
    exp_ready = 1'b0;
    check_outputs("mid_frame_reset");
    idle_bits(12);
    check_outputs("after_abort_idle");

    echo_bits = 12'h000;
    seen      = 1'b0;
    fork
      send_frame(8'h55, 1'b0, 1'b0);
`ifdef UART_RX_ECHO_EN
      begin
        for (int i = 0; i < CPB * 13; i++) begin
          @(negedge clk);
          if (tx_o === 1'b0) begin
            seen = 1'b1;
            break;
          end
        end
        if (seen) begin
          repeat (CPB / 2) @(negedge clk);
          for (int k = 0; k < 12; k++) begin
            echo_bits[k] = tx_o;
            repeat (CPB) @(negedge clk);
          end
        end
      end
`endif
    join
    model_frame(8'h55, 1'b0, 1'b0);
    check_outputs("rx_55");
`ifdef UART_RX_ECHO_EN
    chk("echo_started", {15'h0, seen}, 16'h0001);
    chk("echo_frame", {4'h0, echo_bits}, {4'h0, 2'b11, 1'b0, 8'h55, 1'b0});
`endif
    idle_bits(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
